median3x3_stream: RTL

//  Pipelined, parameter-width 3x3 rank filter with valid/ready handshake on both sides.

---
 rtl/median3x3_stream.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/median3x3_stream.sv
// 3x3 rank filter (median / min / max / centre bypass) over a 9-pixel window, one window per clock.
// Latency: 9/REG_LEVELS cycles from accept to out_valid; each stall cycle adds one.
// Backpressure: out_valid & ~out_ready freezes the whole pipeline and drops in_ready in the same cycle.
module median3x3_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_LEVELS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [9*DATA_WIDTH-1:0] in_win,
    input  logic [1:0]              in_mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [1:0]              out_mode
);

    localparam int LATENCY = 9 / REG_LEVELS;

    typedef logic [DATA_WIDTH-1:0] pix_t;
    typedef logic [8:0][DATA_WIDTH-1:0] vec_t;

    // Everything that travels down one pipeline slot. med is the median
    // network's working set, mn/mx the min/max trees (result ends in
    // element 0), res is only meaningful in the last slot.
    typedef struct packed {
        logic       vld;
        logic [1:0] mode;
        pix_t       ctr;
        vec_t       med;
        vec_t       mn;
        vec_t       mx;
        pix_t       res;
    } stg_t;

    // Compare-exchange node: element a receives the smaller value, b the larger.
    function automatic vec_t cx(input vec_t v, input logic [3:0] a, input logic [3:0] b);
        vec_t r;
        r = v;
        if (v[a] > v[b]) begin
            r[a] = v[b];
            r[b] = v[a];
        end
        return r;
    endfunction

    // Reduction node for the min/max trees: element a absorbs element b.
    function automatic vec_t red(input vec_t v, input logic [3:0] a, input logic [3:0] b,
                                 input logic take_max);
        vec_t r;
        r = v;
        if (take_max ? (v[b] > v[a]) : (v[b] < v[a])) begin
            r[a] = v[b];
        end
        return r;
    endfunction

    // One comparator level (1..9). The median network is the classic
    // 19-node arrangement grouped into 9 dependency levels; the min/max
    // trees finish at level 4 and simply pass through levels 5..9.
    function automatic stg_t apply_level(input stg_t s, input int lvl);
        stg_t r;
        r = s;
        case (lvl)
            1: begin
                r.med = cx(cx(cx(s.med, 4'd1, 4'd2), 4'd4, 4'd5), 4'd7, 4'd8);
                r.mn  = red(red(red(red(s.mn, 4'd0, 4'd1, 1'b0), 4'd2, 4'd3, 1'b0),
                                4'd4, 4'd5, 1'b0), 4'd6, 4'd7, 1'b0);
                r.mx  = red(red(red(red(s.mx, 4'd0, 4'd1, 1'b1), 4'd2, 4'd3, 1'b1),
                                4'd4, 4'd5, 1'b1), 4'd6, 4'd7, 1'b1);
            end
            2: begin
                r.med = cx(cx(cx(s.med, 4'd0, 4'd1), 4'd3, 4'd4), 4'd6, 4'd7);
                r.mn  = red(red(s.mn, 4'd0, 4'd2, 1'b0), 4'd4, 4'd6, 1'b0);
                r.mx  = red(red(s.mx, 4'd0, 4'd2, 1'b1), 4'd4, 4'd6, 1'b1);
            end
            3: begin
                r.med = cx(cx(cx(s.med, 4'd1, 4'd2), 4'd4, 4'd5), 4'd7, 4'd8);
                r.mn  = red(s.mn, 4'd0, 4'd4, 1'b0);
                r.mx  = red(s.mx, 4'd0, 4'd4, 1'b1);
            end
            4: begin
                r.med = cx(cx(cx(s.med, 4'd0, 4'd3), 4'd5, 4'd8), 4'd4, 4'd7);
                r.mn  = red(s.mn, 4'd0, 4'd8, 1'b0);
                r.mx  = red(s.mx, 4'd0, 4'd8, 1'b1);
            end
            5: r.med = cx(cx(cx(s.med, 4'd3, 4'd6), 4'd1, 4'd4), 4'd2, 4'd5);
            6: r.med = cx(s.med, 4'd4, 4'd7);
            7: r.med = cx(s.med, 4'd4, 4'd2);
            8: r.med = cx(s.med, 4'd6, 4'd4);
            9: r.med = cx(s.med, 4'd4, 4'd2);
            default: r = s;
        endcase
        return r;
    endfunction

    // Final 4:1 pick by the mode that travelled with the window.
    function automatic pix_t pick(input stg_t s);
        case (s.mode)
            2'd0:    return s.med[4];
            2'd1:    return s.mn[0];
            2'd2:    return s.mx[0];
            default: return s.ctr;
        endcase
    endfunction

    stg_t stq [LATENCY];
    stg_t src [LATENCY];
    stg_t nxt [LATENCY];
    stg_t head;
    logic stall;

    assign out_valid = stq[LATENCY-1].vld;
    assign out_data  = stq[LATENCY-1].res;
    assign out_mode  = stq[LATENCY-1].mode;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = rst_n & ~stall;

    // Capture the window only on accept; bubbles carry zeros so an
    // undriven in_win never reaches the datapath registers.
    always_comb begin
        head = '0;
        if (in_valid && in_ready) begin
            head.vld  = 1'b1;
            head.mode = in_mode;
            head.ctr  = in_win[4*DATA_WIDTH +: DATA_WIDTH];
            head.med  = in_win;
            head.mn   = in_win;
            head.mx   = in_win;
        end
    end

    // Input of each stage: the new window for stage 0, the previous register otherwise.
    always_comb begin
        src[0] = head;
        for (int k = 1; k < LATENCY; k++) begin
            src[k] = stq[k-1];
        end
    end

    // REG_LEVELS comparator levels per stage; the last stage also forms the output select.
    always_comb begin
        for (int k = 0; k < LATENCY; k++) begin
            stg_t cur;
            cur = src[k];
            for (int j = 0; j < REG_LEVELS; j++) begin
                cur = apply_level(cur, k*REG_LEVELS + j + 1);
            end
            if (k == LATENCY-1) begin
                cur.res = pick(cur);
            end
            nxt[k] = cur;
        end
    end

    // Whole pipeline advances together (bubbles included) unless the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                stq[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < LATENCY; k++) begin
                stq[k] <= nxt[k];
            end
        end
    end

endmodule
